// File: rtl/memory_access_arbiter.sv
// Shares the single-port memory between instruction fetch and load/store with a
// request/grant/done handshake. Optional MEM_ARB_RR_EN selects round-robin tie-breaking.
//
// state      | meaning
// IDLE       | no transaction; samples IfReq/DReq and grants one owner
// ISSUE      | address on the bus; MemWr high for a store; Gnt pulse
// WAIT       | read latency countdown; MemRData captured when counter is 0
// CAPTURE    | read data registered; owner's Done pulse
module memory_access_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              IfReq,
  input  logic [ADDR_W-1:0] IfAddr,
  output logic              IfGnt,
  output logic              IfDone,
  input  logic              DReq,
  input  logic              DWr,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  output logic              DGnt,
  output logic              DDone,
  output logic [DATA_W-1:0] RData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  output logic              Busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(READ_LAT - 1);

  state_t            state_q, state_d;
  logic              own_data_q, own_data_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wdone_q, wdone_d;
  logic              pick_data;

`ifdef MEM_ARB_RR_EN
  // Remembers whether the most recent grant went to the data port.
  logic last_data_q, last_data_d;

  always_comb begin
    pick_data = DReq;
    if (DReq && IfReq) pick_data = !last_data_q;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) last_data_q <= 1'b0;
    else        last_data_q <= last_data_d;
  end

  always_comb begin
    last_data_d = last_data_q;
    if (state_q == ST_IDLE && (IfReq || DReq)) last_data_d = pick_data;
  end
`else
  always_comb pick_data = DReq;
`endif

  always_comb begin
    state_d    = state_q;
    own_data_d = own_data_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    wdone_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (IfReq || DReq) begin
          own_data_d = pick_data;
          addr_d     = pick_data ? DAddr : IfAddr;
          wr_d       = pick_data && DWr;
          if (pick_data) wdata_d = DWData;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (wr_q) begin
          state_d = ST_IDLE;
          wdone_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = MemRData;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      own_data_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      wdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_data_q <= own_data_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      wdone_q    <= wdone_d;
    end
  end

  // Store Done lands in the IDLE cycle after ISSUE; read Done is the CAPTURE cycle.
  assign IfGnt    = (state_q == ST_ISSUE) && !own_data_q;
  assign DGnt     = (state_q == ST_ISSUE) && own_data_q;
  assign IfDone   = (state_q == ST_CAPTURE) && !own_data_q;
  assign DDone    = wdone_q || ((state_q == ST_CAPTURE) && own_data_q);
  assign MemWr    = (state_q == ST_ISSUE) && wr_q;
  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign RData    = rdata_q;
  assign Busy     = (state_q != ST_IDLE);

endmodule

// File: doc/memory_access_arbiter.md
# memory_access_arbiter

Sequences and shares the single-port instruction/data memory between the instruction-fetch path and the load/store path of the multicycle MIPS core. It replaces the hand-counted wait states in the main controller with one request/grant/done handshake per requester. It also owns the memory control lines (address, write strobe, write data) and registers read data for the requester.

## Interface

- `ADDR_W`, 32: memory address width.
- `DATA_W`, 32: memory data width.
- `READ_LAT`, 2: wait cycles after the first address cycle before read data is valid; legal range 1..15.

- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `IfReq` in 1: fetch request, level.
- `IfAddr` in ADDR_W: fetch address.
- `IfGnt` out 1: fetch request accepted, 1-cycle pulse.
- `IfDone` out 1: fetch complete, 1-cycle pulse; `RData` valid.
- `DReq` in 1: data request, level.
- `DWr` in 1: 1 = store, 0 = load.
- `DAddr` in ADDR_W: data address.
- `DWData` in DATA_W: store data.
- `DGnt` out 1: data request accepted, 1-cycle pulse.
- `DDone` out 1: data access complete, 1-cycle pulse.
- `RData` out DATA_W: registered read data; holds until the next read capture.
- `MemAddr` out ADDR_W: memory address.
- `MemWr` out 1: memory write strobe (CtrMem).
- `MemWData` out DATA_W: memory write data.
- `MemRData` in DATA_W: memory read data.
- `Busy` out 1: high whenever state is not IDLE.

## Operation

- States: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE, at a rising edge:
  - No request pending: stay in IDLE.
  - Request pending: select the owner, latch its address, `DWr` and `DWData`, pulse the owner's Gnt, go to ISSUE.
  - A fetch always reads; `MemWData` is don't-care but holds its last value.
- Arbitration when both requests are high:
  - Data wins, by fixed priority (see Configuration).
  - The loser keeps its Req asserted and is served at the next IDLE sample.
- ISSUE:
  - Write: `MemWr`=1 for exactly this cycle, then go to IDLE and pulse `DDone`.
  - Read: go to WAIT with the counter loaded to `READ_LAT`-1.
- WAIT: decrement the counter each cycle. At 0, sample `MemRData` into `RData` and go to CAPTURE.
- CAPTURE: the owner's Done is high for this cycle only. The block returns to IDLE at the next edge.
- `MemAddr` is driven from the latched address in every non-IDLE state and holds its last value in IDLE. No alignment or masking is applied.
- `MemWr` is decoded from state (ISSUE and write), never from inputs.
- Handshake:
  - Req stays high until Gnt is seen.
  - The requester must drop Req in the Gnt cycle; a Req still high in IDLE is a new request.
  - Req and Wr changes while Busy are ignored.
  - Address and data are latched, so requester inputs may change after Gnt.

## Timing

- E0 denotes the accepting edge; C1 is the cycle after E0.
- Gnt is high in C1.
- Write:
  - `MemWr` is high in C1.
  - `DDone` is high in C2, with the state in IDLE.
  - The next request can be accepted at the end of C2.
- Read:
  - The address is stable for C1..C(`READ_LAT`+1).
  - `MemRData` is captured at the end of C(`READ_LAT`+1).
  - Done and the new `RData` appear in C(`READ_LAT`+2).
  - With `READ_LAT`=2, Done is in C4.
- Throughput: one write per 2 cycles; one read per `READ_LAT`+3 cycles.
- Reset asserted, at any time, immediately forces:
  - State to IDLE.
  - All Gnt/Done pulses, `MemWr` and `Busy` to 0.
  - `MemAddr`, `MemWData`, `RData` and the counter to 0.
  - Round-robin pointer to "last = fetch".
- An in-flight transaction is abandoned and not replayed. Deassertion takes effect at the next rising edge.

## Configuration

- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration on simultaneous requests: the requester not granted most recently wins.
  - The pointer updates on every grant.
  - After reset, data wins the first tie.
- `MEM_ARB_RR_EN` undefined: fixed priority, data always wins, and no pointer register exists.
- A single request is granted identically in both builds.

## Test plan

- Reset, then `IfReq`=1 with `IfAddr`=0x40 and `MemRData`=0x8C010004 from C1 onward:
  - `IfGnt` in C1; `MemAddr`=0x40 in C1..C3.
  - `IfDone` in C4 with `RData`=0x8C010004; `MemWr` stays 0 throughout.
- `DReq`=1, `DWr`=1, `DAddr`=0x100, `DWData`=0xDEADBEEF:
  - `DGnt` and `MemWr` in C1 only; `MemAddr`=0x100 and `MemWData`=0xDEADBEEF in C1.
  - `DDone` in C2; `Busy` low in C2.
- `IfReq` and `DReq` (load) both high and held:
  - Fixed-priority build: `DGnt` first, `IfGnt` at the next IDLE.
  - `MEM_ARB_RR_EN` build, after a data grant: the next tie is granted to fetch.
- Change `IfAddr` and `DReq` during WAIT: `MemAddr`, state and Done are unaffected, and no grant is issued until IDLE.
- Assert `Reset` in C2 of a read: all outputs go to 0 in the same cycle; after release, `IfDone` never pulses and `Busy`=0.
- Sweep `READ_LAT`=1 and 5: Done lands in C3 and C7 respectively.
